// File: rtl/rram_ctrl_pkg.sv
// Shared types and default widths for the RRAM write-verify controller.
package rram_ctrl_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 4;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    VREAD,
    VCHECK,
    READ,
    RWAIT,
    RESP
  } state_e;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } op_e;

endpackage

// File: rtl/rram_wv_stats.sv
// Saturating 32-bit event counters for the write-verify controller:
// index 0 = WRITE cycles, 1 = retries, 2 = failed responses.
module rram_wv_stats (
  input  logic        clk0,
  input  logic        rstb0,
  input  logic        inc_write,
  input  logic        inc_retry,
  input  logic        inc_fail,
  output logic [31:0] stat_writes,
  output logic [31:0] stat_retries,
  output logic [31:0] stat_fails
);

  logic [2:0]       inc;
  logic [2:0][31:0] cnt_q;

  assign inc = {inc_fail, inc_retry, inc_write};

  // Each counter sticks at all-ones instead of wrapping.
  always_ff @(posedge clk0 or negedge rstb0) begin
    if (!rstb0) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (inc[i] && (cnt_q[i] != 32'hFFFF_FFFF)) cnt_q[i] <= cnt_q[i] + 32'd1;
      end
    end
  end

  assign stat_writes  = cnt_q[0];
  assign stat_retries = cnt_q[1];
  assign stat_fails   = cnt_q[2];

endmodule

// File: rtl/rram_write_verify_ctrl.sv
// Write-verify sequencer in front of a single-port RRAM macro. Writes are
// read back and compared, re-written on mismatch up to MAX_TRIES times;
// reads pass straight through. Macro command outputs are registered and
// loaded from the next state, so each command occupies exactly the cycle
// of its state. Optional counters: define RRAM_WV_STATS_EN.
module rram_write_verify_ctrl
  import rram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int MAX_TRIES  = 4,
  localparam int TW        = $clog2(MAX_TRIES + 1)
) (
  input  logic                  clk0,
  input  logic                  rstb0,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [TW-1:0]         rsp_tries,
  output logic                  mem_csb0,
  output logic                  mem_web0,
  output logic [ADDR_WIDTH-1:0] mem_addr0,
  output logic [DATA_WIDTH-1:0] mem_din0,
  input  logic [DATA_WIDTH-1:0] mem_dout0
`ifdef RRAM_WV_STATS_EN
  ,
  output logic [31:0]           stat_writes,
  output logic [31:0]           stat_retries,
  output logic [31:0]           stat_fails
`endif
);

  state_e                state_q, state_n;
  op_e                   op_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [TW-1:0]         tries_q;
  logic                  err_q;
  logic                  accept;
  logic                  match;
  logic                  can_retry;

  assign req_ready = (state_q == IDLE);
  assign accept    = req_ready && req_valid;
  assign can_retry = (tries_q < TW'(MAX_TRIES));
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign rsp_tries = (op_q == OP_WRITE) ? tries_q : '0;

  // State register.
  always_ff @(posedge clk0 or negedge rstb0) begin
    if (!rstb0) state_q <= IDLE;
    else        state_q <= state_n;
  end

  // Next state; an unknown read-back falls into the mismatch branch.
  always_comb begin
    state_n = state_q;
    match   = 1'b0;
    if (mem_dout0 == wdata_q) match = 1'b1;
    case (state_q)
      IDLE:   if (accept) state_n = req_write ? WRITE : READ;
      WRITE:  state_n = VREAD;
      VREAD:  state_n = VCHECK;
      VCHECK: state_n = (match || !can_retry) ? RESP : WRITE;
      READ:   state_n = RWAIT;
      RWAIT:  state_n = RESP;
      RESP:   if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Request latches, attempt count and response capture.
  always_ff @(posedge clk0 or negedge rstb0) begin
    if (!rstb0) begin
      op_q    <= OP_READ;
      wdata_q <= '0;
      rdata_q <= '0;
      tries_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= req_write ? OP_WRITE : OP_READ;
        wdata_q <= req_wdata;
        tries_q <= '0;
        err_q   <= 1'b0;
      end
      if (state_q == WRITE) tries_q <= tries_q + TW'(1);
      if (state_q == VCHECK) begin
        rdata_q <= mem_dout0;
        err_q   <= !match && !can_retry;
      end
      if (state_q == RWAIT) rdata_q <= mem_dout0;
    end
  end

  // Macro command registers, driven from the state being entered.
  always_ff @(posedge clk0 or negedge rstb0) begin
    if (!rstb0) begin
      mem_csb0  <= 1'b1;
      mem_web0  <= 1'b1;
      mem_addr0 <= '0;
      mem_din0  <= '0;
    end else begin
      mem_csb0 <= !(state_n inside {WRITE, VREAD, READ});
      mem_web0 <= (state_n != WRITE);
      if (accept) begin
        mem_addr0 <= req_addr;
        mem_din0  <= req_wdata;
      end
    end
  end

`ifdef RRAM_WV_STATS_EN
  rram_wv_stats u_stats (
    .clk0         (clk0),
    .rstb0        (rstb0),
    .inc_write    (state_q == WRITE),
    .inc_retry    ((state_q == VCHECK) && !match && can_retry),
    .inc_fail     ((state_q == VCHECK) && !match && !can_retry),
    .stat_writes  (stat_writes),
    .stat_retries (stat_retries),
    .stat_fails   (stat_fails)
  );
`endif

endmodule

// File: tb/tb_rram_write_verify_ctrl.sv
// Directed bench for rram_write_verify_ctrl: behavioural 1RW macro with
// one-cycle read latency plus a stuck-at-0 wrapper on dout bit 0.
// Stats checks are compiled in when RRAM_WV_STATS_EN is defined.
module tb_rram_write_verify_ctrl;

  logic        clk0 = 1'b0;
  logic        rstb0;
  logic        req_valid, req_ready, req_write;
  logic [3:0]  req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [15:0] rsp_rdata;
  logic [2:0]  rsp_tries;
  logic        mem_csb0, mem_web0;
  logic [3:0]  mem_addr0;
  logic [15:0] mem_din0, mem_dout0;
`ifdef RRAM_WV_STATS_EN
  logic [31:0] stat_writes, stat_retries, stat_fails;
`endif

  int errors = 0;
  int checks = 0;

  // macro model
  logic [15:0] mem [0:15];
  logic [15:0] dout_raw = 16'h0;
  int rd_cnt  = 0;
  int wr_cnt  = 0;
  int act_cnt = 0;
  int rd_base = 0;
  int stuck_n = 0;

  always #5 clk0 = ~clk0;

  always @(posedge clk0) begin
    if (!mem_csb0) begin
      act_cnt <= act_cnt + 1;
      if (!mem_web0) begin
        mem[mem_addr0] <= mem_din0;
        wr_cnt <= wr_cnt + 1;
      end else begin
        dout_raw <= mem[mem_addr0];
        rd_cnt <= rd_cnt + 1;
      end
    end
  end

  assign mem_dout0 = ((rd_cnt - rd_base) >= 1 && (rd_cnt - rd_base) <= stuck_n)
                     ? (dout_raw & 16'hFFFE) : dout_raw;

  rram_write_verify_ctrl dut (
    .clk0(clk0), .rstb0(rstb0),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_tries(rsp_tries),
    .mem_csb0(mem_csb0), .mem_web0(mem_web0), .mem_addr0(mem_addr0),
    .mem_din0(mem_din0), .mem_dout0(mem_dout0)
`ifdef RRAM_WV_STATS_EN
    , .stat_writes(stat_writes), .stat_retries(stat_retries), .stat_fails(stat_fails)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk0);
    #1;
  endtask

  task automatic start_req(input logic w, input logic [3:0] a, input logic [15:0] d);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
  endtask

  // Edges from now until rsp_valid, bounded.
  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
      req_valid = 1'b0;
    end while (!rsp_valid && lat < 60);
    chk("rsp_timeout", {31'd0, rsp_valid}, 32'd1);
  endtask

  task automatic handshake;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  int lat, w0, a0;
  logic [15:0] held;
`ifdef RRAM_WV_STATS_EN
  logic [31:0] r0, f0;
`endif

  initial begin
    rstb0 = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;

    // 1 reset
    #2 rstb0 = 1'b0;
    #1;
    chk("rst_csb", {31'd0, mem_csb0}, 32'd1);
    chk("rst_web", {31'd0, mem_web0}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    repeat (3) tick();
    rstb0 = 1'b1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rdata", {16'd0, rsp_rdata}, 32'd0);
    chk("rst_tries", {29'd0, rsp_tries}, 32'd0);
    chk("rst_addr", {28'd0, mem_addr0}, 32'd0);
    a0 = act_cnt;
    repeat (10) tick();
    chk("rst_idle_activity", act_cnt - a0, 32'd0);

    // 2 write then read
    start_req(1'b1, 4'd3, 16'hA5A5);
    wait_rsp(lat);
    chk("wr_lat", lat, 32'd4);
    chk("wr_err", {31'd0, rsp_err}, 32'd0);
    chk("wr_tries", {29'd0, rsp_tries}, 32'd1);
    chk("wr_rdata", {16'd0, rsp_rdata}, 32'hA5A5);
    handshake();
    start_req(1'b0, 4'd3, 16'h0000);
    wait_rsp(lat);
    chk("rd_lat", lat, 32'd3);
    chk("rd_rdata", {16'd0, rsp_rdata}, 32'hA5A5);
    chk("rd_tries", {29'd0, rsp_tries}, 32'd0);
    handshake();

    // 3 two stuck read-backs then recovery
    rd_base = rd_cnt; stuck_n = 2; w0 = wr_cnt;
`ifdef RRAM_WV_STATS_EN
    r0 = stat_retries;
`endif
    start_req(1'b1, 4'd7, 16'h0001);
    wait_rsp(lat);
    chk("retry_lat", lat, 32'd10);
    chk("retry_err", {31'd0, rsp_err}, 32'd0);
    chk("retry_tries", {29'd0, rsp_tries}, 32'd3);
    chk("retry_writes", wr_cnt - w0, 32'd3);
    chk("retry_rdata", {16'd0, rsp_rdata}, 32'h0001);
`ifdef RRAM_WV_STATS_EN
    chk("stat_retries2", stat_retries - r0, 32'd2);
`endif
    handshake();

    // 4 permanent stuck bit
    rd_base = rd_cnt; stuck_n = 1000; w0 = wr_cnt;
`ifdef RRAM_WV_STATS_EN
    r0 = stat_retries; f0 = stat_fails;
`endif
    start_req(1'b1, 4'd0, 16'hFFFF);
    wait_rsp(lat);
    chk("fail_lat", lat, 32'd13);
    chk("fail_err", {31'd0, rsp_err}, 32'd1);
    chk("fail_tries", {29'd0, rsp_tries}, 32'd4);
    chk("fail_writes", wr_cnt - w0, 32'd4);
    chk("fail_rdata", {16'd0, rsp_rdata}, 32'hFFFE);
`ifdef RRAM_WV_STATS_EN
    chk("stat_fails", stat_fails - f0, 32'd1);
    chk("stat_retries3", stat_retries - r0, 32'd3);
`endif
    handshake();
    stuck_n = 0;

    // 5 backpressure with a pending request
    start_req(1'b0, 4'd7, 16'h0000);
    wait_rsp(lat);
    chk("bp_rd_lat", lat, 32'd3);
    held = rsp_rdata;
    chk("bp_rdata", {16'd0, held}, 32'h0001);
    start_req(1'b1, 4'd5, 16'h1234);
    a0 = act_cnt;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_stable_rdata", {16'd0, rsp_rdata}, {16'd0, held});
    end
    chk("bp_valid_held", {31'd0, rsp_valid}, 32'd1);
    chk("bp_no_ready", {31'd0, req_ready}, 32'd0);
    chk("bp_no_activity", act_cnt - a0, 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_rsp_drop", {31'd0, rsp_valid}, 32'd0);
    chk("bp_bubble_ready", {31'd0, req_ready}, 32'd1);
    chk("bp_bubble_csb", {31'd0, mem_csb0}, 32'd1);
    tick();
    chk("bp_accept_ready", {31'd0, req_ready}, 32'd0);
    chk("bp_accept_csb", {31'd0, mem_csb0}, 32'd0);
    chk("bp_accept_web", {31'd0, mem_web0}, 32'd0);
    chk("bp_accept_addr", {28'd0, mem_addr0}, 32'd5);
    wait_rsp(lat);
    chk("bp_wr_lat", lat, 32'd3);
    chk("bp_wr_tries", {29'd0, rsp_tries}, 32'd1);
    handshake();

    // 6 reset during VREAD
    start_req(1'b1, 4'd9, 16'h5555);
    tick();
    req_valid = 1'b0;
    tick();
    chk("vread_csb", {31'd0, mem_csb0}, 32'd0);
    chk("vread_web", {31'd0, mem_web0}, 32'd1);
    #2 rstb0 = 1'b0;
    #1;
    chk("abort_csb", {31'd0, mem_csb0}, 32'd1);
    chk("abort_rsp", {31'd0, rsp_valid}, 32'd0);
    repeat (2) tick();
    rstb0 = 1'b1;
    repeat (2) tick();
    chk("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
    start_req(1'b0, 4'd3, 16'h0000);
    wait_rsp(lat);
    chk("post_rst_lat", lat, 32'd3);
    chk("post_rst_rdata", {16'd0, rsp_rdata}, 32'hA5A5);
    handshake();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
